// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Logic, add/sub and compare results appear one cycle after acceptance.
// The optional multiply is an unsigned shift-add over WIDTH cycles and is
// built only when ALU_PIPE_MUL_EN is defined; otherwise opcode 1000 is undefined.
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_control,
  input  logic [2:0]       cmp_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpCmp  = 4'b0111;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpNand = 4'b1101;

  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_out_valid;

  logic             w_idle;
  logic             w_accept;
  logic             w_start_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_result;
  logic             w_mul_overflow;

  // Add/sub share the extended-width form so the carry out is bit WIDTH.
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_lt;
  logic             w_eq;
  logic             w_cmp_bit;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_cout;
  logic             w_alu_overflow;

  assign w_add = {1'b0, src1} + {1'b0, src2};
  assign w_sub = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};

  // Sign-based overflow is equivalent to carry-in XOR carry-out of the MSB.
  assign w_add_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (w_add[WIDTH-1] != src1[WIDTH-1]);
  assign w_sub_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (w_sub[WIDTH-1] != src1[WIDTH-1]);
  assign w_lt      = w_sub[WIDTH-1] ^ w_sub_ovf;
  assign w_eq      = (src1 == src2);

  // Signed compare decode.
  always_comb begin
    w_cmp_bit = 1'b0;
    case (cmp_control)
      3'b000:  w_cmp_bit = w_lt;
      3'b001:  w_cmp_bit = !w_lt && !w_eq;
      3'b010:  w_cmp_bit = w_lt || w_eq;
      3'b011:  w_cmp_bit = !w_lt;
      3'b110:  w_cmp_bit = w_eq;
      3'b100:  w_cmp_bit = !w_eq;
      default: w_cmp_bit = 1'b0;
    endcase
  end

  // Single-cycle result and flags; unknown opcodes (and 1000 here) give zeros.
  always_comb begin
    w_alu_result   = '0;
    w_alu_cout     = 1'b0;
    w_alu_overflow = 1'b0;
    case (alu_control)
      OpAnd:  w_alu_result = src1 & src2;
      OpOr:   w_alu_result = src1 | src2;
      OpNor:  w_alu_result = ~(src1 | src2);
      OpNand: w_alu_result = ~(src1 & src2);
      OpAdd: begin
        w_alu_result   = w_add[WIDTH-1:0];
        w_alu_cout     = w_add[WIDTH];
        w_alu_overflow = w_add_ovf;
      end
      OpSub: begin
        w_alu_result   = w_sub[WIDTH-1:0];
        w_alu_cout     = w_sub[WIDTH];
        w_alu_overflow = w_sub_ovf;
      end
      OpCmp: begin
        w_alu_result   = {{(WIDTH-1){1'b0}}, w_cmp_bit};
        w_alu_cout     = w_sub[WIDTH];
        w_alu_overflow = w_sub_ovf;
      end
      default: ;
    endcase
  end

  assign in_ready = w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0]  OpMul   = 4'b1000;
  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH:0]    w_sum;
  logic [2*WIDTH-1:0] w_step;

  // Partial product lives in {r_hi, r_lo}; the multiplier shifts out of r_lo.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_step = {w_sum, r_lo[WIDTH-1:1]};

  assign w_idle         = (r_state == StIdle);
  assign w_start_mul    = w_accept && (alu_control == OpMul);
  assign w_mul_done     = (r_state == StMul) && (r_cnt == CntLast);
  assign w_mul_result   = w_step[WIDTH-1:0];
  assign w_mul_overflow = |w_step[2*WIDTH-1:WIDTH];
  assign busy           = (r_state == StMul);

  // Multiply FSM: one multiplier bit per cycle for WIDTH cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start_mul) begin
            r_mcand <= src1;
            r_lo    <= src2;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_state <= StMul;
          end
        end
        StMul: begin
          r_hi <= w_step[2*WIDTH-1:WIDTH];
          r_lo <= w_step[WIDTH-1:0];
          if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
`else
  assign w_idle         = 1'b1;
  assign w_start_mul    = 1'b0;
  assign w_mul_done     = 1'b0;
  assign w_mul_result   = '0;
  assign w_mul_overflow = 1'b0;
  assign busy           = 1'b0;
`endif

  // Output register: load on completion, otherwise hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_mul_done) begin
      r_result    <= w_mul_result;
      r_cout      <= 1'b0;
      r_overflow  <= w_mul_overflow;
      r_out_valid <= 1'b1;
    end else if (w_accept && !w_start_mul) begin
      r_result    <= w_alu_result;
      r_cout      <= w_alu_cout;
      r_overflow  <= w_alu_overflow;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): vector table through a
// scoreboard queue, plus hand sequences for backpressure, multiply and reset.
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   alu_control;
  logic [2:0]   cmp_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;
  logic         busy;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .alu_control(alu_control), .cmp_control(cmp_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [2:0]   cm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   nout = 0;
  bit   busy_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a result is compared on the cycle the consumer takes it.
  always @(negedge clk) begin
    if (!rst && busy) busy_seen = 1'b1;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL out%0d unexpected: got result %0h expected no output", nout, result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("out%0d.result", nout), result, e.res);
        chk($sformatf("out%0d.zero", nout), zero, e.z);
        chk($sformatf("out%0d.cout", nout), cout, e.c);
        chk($sformatf("out%0d.overflow", nout), overflow, e.v);
      end
      nout++;
    end
  end

  task automatic send(input logic [3:0] op, input logic [2:0] cm, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit push, input exp_t e);
    bit acc = 1'b0;
    alu_control = op;
    cmp_control = cm;
    src1        = a;
    src2        = b;
    in_valid    = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        if (push) q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({name, ".drain"}, q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".out_valid"}, out_valid, 0);
    chk({name, ".result"}, result, 0);
    chk({name, ".zero"}, zero, 1);
    chk({name, ".cout"}, cout, 0);
    chk({name, ".overflow"}, overflow, 0);
    chk({name, ".busy"}, busy, 0);
  endtask

  vec_t vecs[18];
  exp_t ex;
  exp_t none = '{res: '0, z: 1'b0, c: 1'b0, v: 1'b0};

  initial begin
    vecs[0]  = '{4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 0, 0, 1}};
    vecs[1]  = '{4'b0110, 3'b000, 32'h0000_0005, 32'h0000_0005, '{32'h0000_0000, 1, 1, 0}};
    vecs[2]  = '{4'b0111, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0001, 0, 1, 0}};
    vecs[3]  = '{4'b0111, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1, 1, 0}};
    vecs[4]  = '{4'b0000, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 0, 0, 0}};
    vecs[5]  = '{4'b0001, 3'b000, 32'h0F0F_0000, 32'h0000_00F0, '{32'h0F0F_00F0, 0, 0, 0}};
    vecs[6]  = '{4'b1100, 3'b000, 32'h0000_0000, 32'h0000_0000, '{32'hFFFF_FFFF, 0, 0, 0}};
    vecs[7]  = '{4'b1101, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h0000_0000, 1, 0, 0}};
    vecs[8]  = '{4'b0010, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1, 1, 0}};
    vecs[9]  = '{4'b0110, 3'b000, 32'h0000_0000, 32'h0000_0001, '{32'hFFFF_FFFF, 0, 0, 0}};
    vecs[10] = '{4'b0110, 3'b000, 32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 0, 1, 1}};
    vecs[11] = '{4'b0111, 3'b110, 32'h0000_0003, 32'h0000_0003, '{32'h0000_0001, 0, 1, 0}};
    vecs[12] = '{4'b0111, 3'b100, 32'h0000_0003, 32'h0000_0003, '{32'h0000_0000, 1, 1, 0}};
    vecs[13] = '{4'b0111, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, '{32'h0000_0001, 0, 0, 0}};
    vecs[14] = '{4'b0111, 3'b010, 32'h0000_0002, 32'h0000_0002, '{32'h0000_0001, 0, 1, 0}};
    vecs[15] = '{4'b0111, 3'b111, 32'h0000_0002, 32'h0000_0002, '{32'h0000_0000, 1, 1, 0}};
    vecs[16] = '{4'b0011, 3'b000, 32'h1234_5678, 32'h0000_0001, '{32'h0000_0000, 1, 0, 0}};
    vecs[17] = '{4'b0010, 3'b000, 32'h0000_0001, 32'h0000_0002, '{32'h0000_0003, 0, 0, 0}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; alu_control = '0; cmp_control = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Vector table, issued back to back.
    foreach (vecs[i]) send(vecs[i].op, vecs[i].cm, vecs[i].a, vecs[i].b, 1'b1, vecs[i].e);
    drain("table");

    // Three back-to-back ADDs, then backpressure on the last result.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_control = 4'b0010;
    cmp_control = 3'b000;
    for (int i = 0; i < 3; i++) begin
      src1 = 32'(10 * (i + 1));
      src2 = 32'd5;
      @(negedge clk);
      chk($sformatf("b2b%0d.in_ready", i), in_ready, 1);
      if (i > 0) chk($sformatf("b2b%0d.out_valid", i), out_valid, 1);
      q.push_back('{32'(10 * (i + 1) + 5), 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.out_valid", i), out_valid, 1);
      chk($sformatf("hold%0d.result", i), result, 32'd35);
      chk($sformatf("hold%0d.in_ready", i), in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("b2b");

`ifdef ALU_PIPE_MUL_EN
    // Multiply: latency and busy window, then a small product.
    begin
      int  nbusy = 0;
      bit  seen = 1'b0;
      send(4'b1000, 3'b000, 32'h0001_0000, 32'h0001_0000, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1});
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        else if (busy) nbusy++;
      end
      chk("mul_big.busy_cycles", nbusy, 32);
      chk("mul_big.out_valid_seen", seen, 1);
      chk("mul_big.busy_after", busy, 0);
      @(posedge clk); #1;
      drain("mul_big");
      send(4'b1000, 3'b000, 32'd7, 32'd6, 1'b1, '{32'd42, 1'b0, 1'b0, 1'b0});
      drain("mul_small");
      send(4'b1000, 3'b000, 32'hFFFF_FFFF, 32'd3, 1'b1, '{32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1});
      drain("mul_wrap");
    end
    // Reset in the middle of a multiply.
    out_ready = 1'b1;
    send(4'b1000, 3'b000, 32'd7, 32'd6, 1'b0, none);
    repeat (10) @(posedge clk);
    #1;
    chk("mul_rst.busy_before", busy, 1);
`else
    // Opcode 1000 is undefined without the multiplier.
    send(4'b1000, 3'b000, 32'd7, 32'd6, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("mul_undef.out_valid", out_valid, 1);
    drain("mul_undef");
    chk("mul_undef.busy_seen", busy_seen, 0);
    // Reset while a result is held under backpressure.
    out_ready = 1'b0;
    send(4'b0010, 3'b000, 32'd9, 32'd9, 1'b0, none);
    @(negedge clk);
    chk("mul_rst.held_before", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
`endif
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(4'b0010, 3'b000, 32'd1, 32'd2, 1'b1, '{32'd3, 1'b0, 1'b0, 1'b0});
    drain("post_rst");
    begin
      int nv = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid) nv++;
      end
      chk("post_rst.no_stray_output", nv, 0);
    end
    chk("outputs_seen", nout, 18 + 3 +
`ifdef ALU_PIPE_MUL_EN
        3 +
`else
        1 +
`endif
        1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
